// File: rtl/pc_fetch_controller.sv
// Program counter and instruction-fetch sequencer: owns the PC, issues one
// req/ack fetch per instruction, and applies branch/jump redirects, stall and timeout.
module pc_fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        IMemAck,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   output logic [31:0] PCResult,
   output logic [31:0] PCAddResult,
   output logic        InstrValid,
   output logic        FetchTimeout
);

   localparam int unsigned AW = 32;
   localparam int unsigned WW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          pend_v_q, pend_v_d;
   logic [AW-1:0] pend_tgt_q, pend_tgt_d;
   logic          valid_q, valid_d;
   logic          timeout_q, timeout_d;

   logic [AW-1:0] pc_plus4;
   logic          redir_v;
   logic [AW-1:0] redir_tgt;

   assign pc_plus4  = pc_q + AW'(4);
   assign redir_v   = Jump | BranchTaken;
   // Jump beats branch when both arrive together; targets are word-aligned on load.
   assign redir_tgt = Jump ? (JumpTarget & ~AW'(3)) : (BranchTarget & ~AW'(3));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wait_d     = wait_q;
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (IMemAck) begin
               if (pend_v_q)     pc_d = pend_tgt_q;
               else if (redir_v) pc_d = redir_tgt;
               else              pc_d = pc_plus4;
               pend_v_d = 1'b0;
               wait_d   = '0;
               valid_d  = 1'b1;
               state_d  = Stall ? HOLD : FETCH;
            end else begin
               wait_d = wait_q + WW'(1);
               if (redir_v) begin
                  pend_v_d   = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
               if (wait_d == WW'(MAX_WAIT)) begin
                  state_d   = ERR;
                  timeout_d = 1'b1;
               end
            end
         end
         HOLD: begin
            // Redirects seen while stalled are held until the next accepted fetch.
            if (redir_v) begin
               pend_v_d   = 1'b1;
               pend_tgt_d = redir_tgt;
            end
            if (!Stall) state_d = FETCH;
         end
         ERR: timeout_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         wait_q     <= '0;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wait_q     <= wait_d;
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
      end
   end

   assign IMemReq      = (state_q == FETCH);
   assign IMemAddr     = pc_q;
   assign PCResult     = pc_q;
   assign PCAddResult  = pc_plus4;
   assign InstrValid   = valid_q;
   assign FetchTimeout = timeout_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Randomized scoreboard bench for pc_fetch_controller against a cycle-level
// behavioural model of the fetch rules.
module tb_pc_fetch_controller;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
   localparam int          MAXW   = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Stall = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = '0;
   logic        IMemAck = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic [31:0] PCResult;
   logic [31:0] PCAddResult;
   logic        InstrValid;
   logic        FetchTimeout;

   pc_fetch_controller #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget), .IMemAck(IMemAck),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .PCResult(PCResult),
      .PCAddResult(PCAddResult), .InstrValid(InstrValid),
      .FetchTimeout(FetchTimeout)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: PC, whether fetching has begun, stalled, dead, pending redirect.
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_pend = '0;
   bit          m_pend_v = 0;
   bit          m_started = 0;
   bit          m_stalled = 0;
   bit          m_dead = 0;
   bit          m_vexp = 0;
   int          m_wait = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic note_redirect();
      if (Jump) begin
         m_pend_v = 1;
         m_pend   = {JumpTarget[31:2], 2'b00};
      end else if (BranchTaken) begin
         m_pend_v = 1;
         m_pend   = {BranchTarget[31:2], 2'b00};
      end
   endtask

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_pc = RST_PC; m_pend_v = 0; m_started = 0; m_stalled = 0;
         m_dead = 0; m_vexp = 0; m_wait = 0;
         exp_q.delete();
      end else if (!m_started) begin
         m_started = 1;
         m_vexp    = 0;
      end else begin
         m_vexp = 0;
         if (m_dead) begin
            m_vexp = 0;
         end else if (m_stalled) begin
            note_redirect();
            if (!Stall) m_stalled = 0;
         end else if (IMemAck) begin
            if (m_pend_v)         m_pc = m_pend;
            else if (Jump)        m_pc = {JumpTarget[31:2], 2'b00};
            else if (BranchTaken) m_pc = {BranchTarget[31:2], 2'b00};
            else                  m_pc = m_pc + 32'd4;
            exp_q.push_back(m_pc);
            m_pend_v  = 0;
            m_wait    = 0;
            m_vexp    = 1;
            m_stalled = Stall;
         end else begin
            m_wait++;
            note_redirect();
            if (m_wait >= MAXW) m_dead = 1;
         end
      end
   end

   // Monitor: per-cycle output checks plus scoreboard pop on every InstrValid pulse.
   always @(negedge Clk) begin
      if (Reset) begin
         check("imem_req", 32'(IMemReq), 32'(m_started && !m_stalled && !m_dead));
         check("pc", PCResult, m_pc);
         check("pc_plus4", PCAddResult, m_pc + 32'd4);
         check("imem_addr", IMemAddr, m_pc);
         check("timeout", 32'(FetchTimeout), 32'(m_dead));
         check("instr_valid", 32'(InstrValid), 32'(m_vexp));
         if (InstrValid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_unexpected: InstrValid with pc %h but nothing expected", PCResult);
            end else begin
               check("sb_pc", PCResult, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int budget;
      Reset = 1'b0;
      IMemAck = 1'b1;
      repeat (2) @(negedge Clk);
      check("rst_pc", PCResult, RST_PC);
      check("rst_pc4", PCAddResult, RST_PC + 32'd4);
      check("rst_req", 32'(IMemReq), 32'd0);
      check("rst_valid", 32'(InstrValid), 32'd0);
      check("rst_timeout", 32'(FetchTimeout), 32'd0);
      Reset = 1'b1;

      // Back-to-back sequential fetches, wrapping through 0xFFFFFFFC -> 0.
      repeat (8) @(negedge Clk);

      // Random traffic; ack forced before the wait budget runs out.
      repeat (400) begin
         @(negedge Clk);
         IMemAck      = ($urandom_range(0, 9) < 6) || (m_wait >= MAXW - 1);
         Stall        = ($urandom_range(0, 9) < 2);
         Jump         = ($urandom_range(0, 9) == 0);
         BranchTaken  = ($urandom_range(0, 9) < 2);
         JumpTarget   = $urandom;
         BranchTarget = $urandom;
      end

      // Starve the fetch until timeout.
      @(negedge Clk);
      IMemAck = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
      budget = 20;
      while (!FetchTimeout && budget > 0) begin
         @(negedge Clk);
         budget--;
      end
      if (!FetchTimeout) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout_wait: FetchTimeout still %b after 20 cycles", FetchTimeout);
      end

      // Acks and redirects in ERR must be ignored.
      IMemAck = 1'b1; Jump = 1'b1; JumpTarget = 32'h0000_4000;
      repeat (4) @(negedge Clk);
      Jump = 1'b0;

      // Asynchronous reset between clock edges.
      @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      check("async_timeout", 32'(FetchTimeout), 32'd0);
      check("async_pc", PCResult, RST_PC);
      check("async_req", 32'(IMemReq), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      IMemAck = 1'b1;
      repeat (6) @(negedge Clk);
      IMemAck = 1'b0;
      @(negedge Clk);
      @(negedge Clk);

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequences the program counter and instruction-memory fetch for the single-issue MIPS datapath. Holds the PC register and computes PC+4 internally. Issues one fetch request per instruction to instruction memory through a req/ack handshake. Selects the next PC from sequential, branch or jump sources, and supports pipeline stall and a fetch timeout.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
MAX_WAIT, 15, FETCH cycles without ack before timeout (range 1..255)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold off the next fetch after the current one completes
BranchTaken  input  1  branch redirect request
BranchTarget  input  32  branch destination address
Jump  input  1  jump redirect request
JumpTarget  input  32  jump destination address
IMemAck  input  1  instruction memory has returned data for IMemAddr
IMemReq  output  1  fetch request
IMemAddr  output  32  fetch address; always equals PCResult
PCResult  output  32  current PC
PCAddResult  output  32  PCResult + 4
InstrValid  output  1  one-cycle pulse: instruction at previous PC accepted
FetchTimeout  output  1  sticky error flag

Behaviour:
- Reset (Reset=0, async, overrides everything): PCResult=RESET_PC, PCAddResult=RESET_PC+4, IMemReq=0, InstrValid=0, FetchTimeout=0, state=IDLE, wait counter=0, pending-redirect valid=0. Reset mid-fetch abandons the request immediately.
- Arithmetic: PCAddResult = PCResult+4 mod 2^32 (0xFFFFFFFC -> 0x00000000). Bits [1:0] of BranchTarget and JumpTarget are forced to 0 when loaded.
- States: IDLE, FETCH, HOLD, ERR. IMemReq=1 only in FETCH and is driven combinationally from state.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH, edge with IMemAck=1:
  - Load PCResult from the highest-priority source: pending redirect target, else JumpTarget if Jump=1, else BranchTarget if BranchTaken=1, else PCAddResult.
  - Clear pending and the wait counter.
  - InstrValid=1 for the following cycle.
  - Next state is HOLD if Stall=1, otherwise FETCH, giving back-to-back fetches of 1 instruction/cycle when IMemAck is held high.
- FETCH, edge with IMemAck=0:
  - PC unchanged. Wait counter increments.
  - A Jump or BranchTaken seen on this edge is latched as the pending redirect. Jump wins when both are asserted together. A later redirect overwrites an earlier pending one.
  - When the counter reaches MAX_WAIT, go to ERR.
- HOLD:
  - IMemReq=0; PC held.
  - Redirects are still sampled and latched as pending, with the same priority rules.
  - Go to FETCH on the first edge with Stall=0. The pending redirect is applied at the next ack, so that fetch uses the old PC.
- ERR: IMemReq=0, FetchTimeout=1, PC frozen. Exit only via reset.
- IMemAck outside FETCH is ignored; it produces no InstrValid.
- Stall together with a redirect on an ack edge: the redirect is applied, then HOLD.
- InstrValid is 0 in every cycle not immediately following an accepted ack.

Test Plan:
- Reset and sequential fetch: RESET_PC=0, Reset low then high, IMemAck tied 1 -> IMemReq rises one cycle after release. PCResult steps 0x0, 0x4, 0x8, 0xC on successive edges. InstrValid is high each cycle after the first ack.
- Wrap and PCAddResult: RESET_PC=32'hFFFFFFFC, ack once -> PCAddResult=0x00000000 before the ack, PCResult=0x00000000 after it. Also RESET_PC=32'h00000FFC -> PCAddResult=0x00001000.
- Redirect priority: PC=0x10, ack with Jump=1 (JumpTarget=0x400) and BranchTaken=1 (BranchTarget=0x200) -> PCResult=0x400. Repeat with BranchTarget=0x203 and Jump=0 -> PCResult=0x200.
- Pending redirect during wait: PC=0x20, ack low 3 cycles, BranchTaken pulsed (target 0x80) on cycle 1, then ack -> PCResult=0x80, not 0x24. InstrValid pulses exactly once.
- Stall: ack with Stall=1 at PC=0x8 -> PCResult=0xC, IMemReq=0 while Stall is held for 4 cycles. Ack ignored while in HOLD. IMemReq=1 the cycle after Stall drops.
- Timeout and async reset: MAX_WAIT=4, ack held 0 -> FetchTimeout=1 and IMemReq=0 after 4 FETCH cycles, PC unchanged. Assert Reset between clock edges -> FetchTimeout=0 and PCResult=RESET_PC immediately, without waiting for a clock edge.
